// File: rtl/fft_bram_seq_if.sv
// Control bundle between the FFT address sequencer and the RAM / butterfly datapath.
// The sequencer is the master; the datapath side is the slave.
interface fft_bram_seq_if #(
  parameter int LOG2N = 6
);
  logic             Start;
  logic             Busy;
  logic             Done;
  logic             Ram_En;
  logic             We_A;
  logic             We_B;
  logic [LOG2N-1:0] Addr_A;
  logic [LOG2N-1:0] Addr_B;
  logic             Bf_Valid;
  logic [LOG2N-2:0] Tw_Idx;
  logic [2:0]       Stage;

  modport master (
    input  Start,
    output Busy, Done, Ram_En, We_A, We_B, Addr_A, Addr_B, Bf_Valid, Tw_Idx, Stage
  );

  modport slave (
    output Start,
    input  Busy, Done, Ram_En, We_A, We_B, Addr_A, Addr_B, Bf_Valid, Tw_Idx, Stage
  );
endinterface

// File: rtl/fft_bram_seq.sv
// In-place radix-2 DIF FFT address sequencer: reads on even slots, writes back BF_LAT+1 cycles later on odd slots.
// All outputs registered; no backpressure, a transform runs LOG2N*(N+BF_LAT) cycles once started.
module fft_bram_seq #(
  parameter int LOG2N  = 6,
  parameter int BF_LAT = 2
) (
  input  logic           Clk,
  input  logic           Rst,
  fft_bram_seq_if.master bus
);
  localparam int HALF = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [HALF-1:0]  k;
  logic             phase_odd;
  logic [2:0]       stage;
  logic [BF_LAT:0]  pipe_vld;
  logic [LOG2N-1:0] pipe_a [0:BF_LAT];
  logic [LOG2N-1:0] pipe_b [0:BF_LAT];
  logic [HALF-1:0]  tw_q;

  logic             busy_q, done_q, ram_en_q, we_q, bf_valid_q;
  logic [LOG2N-1:0] addr_a_q, addr_b_q;
  logic [HALF-1:0]  tw_idx_q;

  logic [2:0]       rd_stage;
  logic [HALF-1:0]  rd_k;
  logic [2:0]       p;
  logic [LOG2N-1:0] low_mask, k_ext, rd_a, rd_b;
  logic [HALF-1:0]  rd_tw;
  logic             rd_go, wr_go;

  // Operand addresses for the read that the next cycle will carry.
  always_comb begin
    rd_stage = stage;
    rd_k     = k;
    if (state == IDLE) begin
      rd_stage = '0;
      rd_k     = '0;
    end else if (state == DRAIN) begin
      rd_stage = stage + 3'd1;
      rd_k     = '0;
    end
    p        = 3'(LOG2N - 1) - rd_stage;
    low_mask = (LOG2N'(1) << p) - LOG2N'(1);
    k_ext    = LOG2N'(rd_k);
    rd_a     = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    rd_b     = rd_a | (LOG2N'(1) << p);
    rd_tw    = HALF'((k_ext & low_mask) << rd_stage);

    rd_go = ((state == IDLE) && bus.Start) ||
            ((state == RUN) && phase_odd) ||
            ((state == DRAIN) && (pipe_vld == '0) && (stage != 3'(LOG2N - 1)));
    wr_go = pipe_vld[BF_LAT];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      k          <= '0;
      phase_odd  <= 1'b0;
      stage      <= '0;
      pipe_vld   <= '0;
      for (int i = 0; i <= BF_LAT; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
      tw_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      we_q       <= 1'b0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[BF_LAT-1:0], rd_go};
      pipe_a[0] <= rd_a;
      pipe_b[0] <= rd_b;
      for (int i = 1; i <= BF_LAT; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
      if (rd_go) tw_q <= rd_tw;

      bf_valid_q <= pipe_vld[0];
      if (pipe_vld[0]) tw_idx_q <= tw_q;

      // Writes only ever fall on odd slots, so they never compete with a read.
      ram_en_q <= rd_go | wr_go;
      we_q     <= wr_go;
      if (wr_go) begin
        addr_a_q <= pipe_a[BF_LAT];
        addr_b_q <= pipe_b[BF_LAT];
      end else if (rd_go) begin
        addr_a_q <= rd_a;
        addr_b_q <= rd_b;
      end

      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.Start) begin
          state     <= RUN;
          busy_q    <= 1'b1;
          stage     <= '0;
          k         <= HALF'(1);
          phase_odd <= 1'b0;
        end
        RUN: if (phase_odd) begin
          k         <= k + HALF'(1);
          phase_odd <= 1'b0;
        end else begin
          phase_odd <= 1'b1;
          if (k == '0) state <= DRAIN;
        end
        DRAIN: if (pipe_vld == '0) begin
          if (stage == 3'(LOG2N - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            stage  <= '0;
          end else begin
            state     <= RUN;
            stage     <= stage + 3'd1;
            k         <= HALF'(1);
            phase_odd <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Ram_En   = ram_en_q;
  assign bus.We_A     = we_q;
  assign bus.We_B     = we_q;
  assign bus.Addr_A   = addr_a_q;
  assign bus.Addr_B   = addr_b_q;
  assign bus.Bf_Valid = bf_valid_q;
  assign bus.Tw_Idx   = tw_idx_q;
  assign bus.Stage    = stage;
endmodule

// File: tb/tb_fft_bram_seq.sv
// Directed bench for fft_bram_seq (N=64, BF_LAT=2): cycle-exact timing model, write scoreboard,
// hand-computed address/twiddle points, ignored Start pulses and mid-transform reset.
module tb_fft_bram_seq;
  localparam int LOG2N  = 6;
  localparam int BF_LAT = 2;
  localparam int N      = 64;
  localparam int SLEN   = N + BF_LAT;

  logic Clk = 1'b0;
  logic Rst;

  fft_bram_seq_if #(.LOG2N(LOG2N)) bus ();
  fft_bram_seq #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int wcnt [0:7][0:63];
  int last_wr [0:7];
  int first_rd [0:7];
  int done_cnt, wr_total;
  logic [5:0] ea, eb;
  logic [4:0] etw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  function automatic logic [25:0] outs();
    return {bus.Busy, bus.Done, bus.Ram_En, bus.We_A, bus.We_B, bus.Bf_Valid,
            bus.Stage, bus.Tw_Idx, bus.Addr_A, bus.Addr_B};
  endfunction

  function automatic logic [5:0] a_of(int s, int k);
    int p;
    p = LOG2N - 1 - s;
    return 6'(((k >> p) << (p + 1)) + (k % (1 << p)));
  endfunction

  function automatic logic [5:0] b_of(int s, int k);
    return 6'(int'(a_of(s, k)) + (1 << (LOG2N - 1 - s)));
  endfunction

  function automatic logic [4:0] tw_of(int s, int k);
    return 5'(((k % (1 << (LOG2N - 1 - s))) << s) % 32);
  endfunction

  initial begin
    int j, off, kk, bad;
    bit e_rd, e_wr, e_bv, in_run;

    Rst = 1'b1;
    bus.Start = 1'b0;
    ea = '0; eb = '0; etw = '0;
    done_cnt = 0; wr_total = 0;
    for (int s = 0; s < 8; s++) begin
      last_wr[s]  = -1;
      first_rd[s] = -1;
      for (int a = 0; a < 64; a++) wcnt[s][a] = 0;
    end

    repeat (3) tick();
    chk("reset_outputs", outs(), 26'd0);
    Rst = 1'b0;
    tick();
    chk("idle_outputs", outs(), 26'd0);

    // Full transform; Start accepted in cycle 0, extra pulses at 50 and 397 must be ignored.
    cyc = 0;
    bus.Start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      tick();
      bus.Start = (c == 50 || c == 397);

      j      = (c - 1) / SLEN;
      off    = (c - 1) % SLEN;
      in_run = (c <= LOG2N * SLEN);
      e_rd   = in_run && (off % 2 == 0) && (off < N);
      e_wr   = in_run && (off % 2 == 1) && (off >= 3);
      e_bv   = in_run && (off % 2 == 1) && (off <= N - 1);
      if (e_rd) begin
        kk = off / 2;
        ea = a_of(j, kk);
        eb = b_of(j, kk);
      end
      if (e_wr) begin
        kk = (off - 3) / 2;
        ea = a_of(j, kk);
        eb = b_of(j, kk);
      end
      if (e_bv) etw = tw_of(j, (off - 1) / 2);

      chk("ram_en",   bus.Ram_En,   e_rd | e_wr);
      chk("we_a",     bus.We_A,     e_wr);
      chk("we_b",     bus.We_B,     e_wr);
      chk("addr_a",   bus.Addr_A,   ea);
      chk("addr_b",   bus.Addr_B,   eb);
      chk("bf_valid", bus.Bf_Valid, e_bv);
      chk("tw_idx",   bus.Tw_Idx,   etw);
      chk("busy",     bus.Busy,     in_run);
      chk("done",     bus.Done,     c == LOG2N * SLEN + 1);
      if (c != LOG2N * SLEN + 1) chk("stage", bus.Stage, in_run ? j : 0);

      if (c == 1)   begin chk("t1_rd_a", bus.Addr_A, 0);  chk("t1_rd_b", bus.Addr_B, 32); end
      if (c == 2)   begin chk("t1_bfv", bus.Bf_Valid, 1); chk("t1_tw", bus.Tw_Idx, 0); end
      if (c == 4)   begin chk("t1_we", bus.We_A, 1); chk("t1_wr_a", bus.Addr_A, 0); chk("t1_wr_b", bus.Addr_B, 32); end
      if (c == 99)  begin chk("s1k16_a", bus.Addr_A, 32); chk("s1k16_b", bus.Addr_B, 48); end
      if (c == 100) chk("s1k16_tw", bus.Tw_Idx, 0);
      if (c == 143) begin chk("s2k5_a", bus.Addr_A, 5); chk("s2k5_b", bus.Addr_B, 13); end
      if (c == 144) chk("s2k5_tw", bus.Tw_Idx, 20);
      if (c == 337) begin chk("s5k3_a", bus.Addr_A, 6); chk("s5k3_b", bus.Addr_B, 7); end
      if (c == 396) chk("busy_last", bus.Busy, 1);
      if (c == 397) begin chk("done_397", bus.Done, 1); chk("busy_397", bus.Busy, 0); end

      if (bus.Ram_En === 1'b1 && bus.We_A === 1'b1) begin
        wcnt[j][bus.Addr_A]++;
        wcnt[j][bus.Addr_B]++;
        wr_total++;
        last_wr[j] = c;
      end
      if (bus.Ram_En === 1'b1 && bus.We_A === 1'b0 && first_rd[j] < 0) first_rd[j] = c;
      if (bus.Done === 1'b1) done_cnt++;
    end

    bad = 0;
    for (int s = 0; s < LOG2N; s++)
      for (int a = 0; a < N; a++)
        if (wcnt[s][a] != 1) bad++;
    chk("write_once_per_stage", bad, 0);
    chk("write_total", wr_total, LOG2N * N / 2);
    chk("done_pulses", done_cnt, 1);
    for (int s = 0; s < LOG2N - 1; s++)
      chk("no_early_read", first_rd[s+1] > last_wr[s], 1);

    // Abort mid-transform with reset, then restart cleanly.
    bus.Start = 1'b1;
    cyc = 0;
    tick();
    bus.Start = 1'b0;
    repeat (99) tick();
    chk("pre_rst_write", {bus.Ram_En, bus.We_A, bus.Stage}, {1'b1, 1'b1, 3'd1});
    Rst = 1'b1;
    #1;
    chk("mid_rst_outputs", outs(), 26'd0);
    #1;
    Rst = 1'b0;
    tick();
    chk("post_rst_idle", {bus.Busy, bus.Ram_En}, 2'b00);
    bus.Start = 1'b1;
    cyc = 0;
    tick();
    bus.Start = 1'b0;
    chk("restart_rd", {bus.Busy, bus.Ram_En, bus.We_A, bus.Stage, bus.Addr_A, bus.Addr_B},
        {1'b1, 1'b1, 1'b0, 3'd0, 6'd0, 6'd32});
    tick();
    chk("restart_bfv", bus.Bf_Valid, 1);
    repeat (2) tick();
    chk("restart_wr", {bus.We_A, bus.We_B, bus.Addr_A, bus.Addr_B}, {1'b1, 1'b1, 6'd0, 6'd32});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
